// File: rtl/light_hash_pkg.sv
// Shared command encodings, initial hash value and default round count for light_hash.
package light_hash_pkg;

  typedef enum logic [1:0] {
    CMD_HEAD = 2'b00,
    CMD_TAIL = 2'b01,
    CMD_MSG  = 2'b10,
    CMD_IDLE = 2'b11
  } cmd_e;

  localparam logic [63:0] IV             = 64'h34550F14DAC02BEE;
  localparam int unsigned ROUNDS_DEFAULT = 32;

endpackage

// File: rtl/light_hash_aes_sbox.sv
// Combinational AES forward S-box; entry 0 sits in the most significant byte of the table.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/light_hash.sv
// Byte-serial 64-bit hash: each absorbed byte runs ROUNDS S-box rounds, one per clock.
module light_hash
  import light_hash_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  message_byte,
  input  logic        message_valid,
  input  logic [1:0]  state,
  output logic [63:0] digest,
  output logic        digest_ready
);

  // r_h[0] is the most significant byte so the array reads out directly as the digest
  logic [0:7][7:0] r_h;
  logic [7:0]      r_m;
  logic [7:0]      r_round;
  logic            next_byte;
  logic [63:0]     r_digest;
  logic            r_digest_ready;

  logic [0:7][7:0] w_sbox_in;
  logic [0:7][7:0] w_sbox_out;
  logic [0:7][7:0] w_h_next;
  logic            w_cmd_head;
  logic            w_cmd_msg;
  logic            w_cmd_tail;
  logic            w_last_round;

  assign w_cmd_head   = message_valid && (state == CMD_HEAD);
  assign w_cmd_msg    = message_valid && (state == CMD_MSG);
  assign w_cmd_tail   = message_valid && (state == CMD_TAIL);
  assign w_last_round = (r_round == 8'(ROUNDS - 1));

  for (genvar i = 0; i < 8; i++) begin : g_round
    assign w_sbox_in[i] = r_h[(i + 1) % 8] ^ r_m ^ r_round;

    aes_sbox u_sbox (
      .i_byte (w_sbox_in[i]),
      .o_byte (w_sbox_out[i])
    );

    assign w_h_next[i] = {r_h[i][6:0], r_h[i][7]} ^ w_sbox_out[i];
  end

  // Head outranks an ongoing compression; message/tail are only honoured when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h            <= IV;
      r_m            <= 8'h00;
      r_round        <= 8'h00;
      next_byte      <= 1'b0;
      r_digest       <= 64'h0;
      r_digest_ready <= 1'b0;
    end else if (w_cmd_head) begin
      r_h            <= IV;
      r_round        <= 8'h00;
      next_byte      <= 1'b0;
      r_digest_ready <= 1'b0;
    end else if (next_byte) begin
      r_h <= w_h_next;
      if (w_last_round) begin
        r_round   <= 8'h00;
        next_byte <= 1'b0;
      end else begin
        r_round <= r_round + 8'd1;
      end
    end else if (w_cmd_msg) begin
      r_m            <= message_byte;
      r_round        <= 8'h00;
      next_byte      <= 1'b1;
      r_digest_ready <= 1'b0;
    end else if (w_cmd_tail) begin
      r_digest       <= r_h;
      r_digest_ready <= 1'b1;
    end
  end

  assign digest       = r_digest;
  assign digest_ready = r_digest_ready;

endmodule

// File: tb/tb_light_hash.sv
// Directed bench for light_hash against an independent software model with a computed S-box.
module tb_light_hash;
  import light_hash_pkg::*;

  localparam int          ROUNDS = 32;
  localparam logic [63:0] IV_EXP = 64'h34550F14DAC02BEE;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string       name;
    string       msg;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  message_byte = 8'h00;
  logic        message_valid = 1'b0;
  logic [1:0]  state = 2'b11;
  logic [63:0] digest;
  logic        digest_ready;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbox_m [256];

  light_hash #(.ROUNDS(ROUNDS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .message_byte  (message_byte),
    .message_valid (message_valid),
    .state         (state),
    .digest        (digest),
    .digest_ready  (digest_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the AES affine transform
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] res, pw, s;
    int e;
    res = 8'h01; pw = x; e = 254;
    while (e != 0) begin
      if (e[0]) res = gmul(res, pw);
      pw = gmul(pw, pw);
      e  = e >> 1;
    end
    s = res ^ {res[6:0], res[7]} ^ {res[5:0], res[7:6]} ^ {res[4:0], res[7:5]}
        ^ {res[3:0], res[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] h_in, input bq_t q);
    logic [7:0] h [8];
    logic [7:0] t [8];
    for (int i = 0; i < 8; i++) h[i] = h_in[63-8*i -: 8];
    foreach (q[k]) begin
      for (int r = 0; r < ROUNDS; r++) begin
        for (int i = 0; i < 8; i++)
          t[i] = {h[i][6:0], h[i][7]} ^ sbox_m[h[(i+1)%8] ^ q[k] ^ 8'(r)];
        h = t;
      end
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] c, input logic [7:0] b);
    message_valid = 1'b1;
    state         = c;
    message_byte  = b;
    tick();
    message_valid = 1'b0;
    state         = CMD_IDLE;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dut.next_byte === 1'b1 && n < ROUNDS + 10) begin
      tick();
      n++;
    end
    if (dut.next_byte !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%b required=0", dut.next_byte);
    end
  endtask

  task automatic hash_q(input bq_t q, output logic [63:0] d);
    pulse(CMD_HEAD, 8'h00);
    foreach (q[k]) begin
      pulse(CMD_MSG, q[k]);
      wait_idle();
    end
    pulse(CMD_TAIL, 8'h00);
    d = digest;
  endtask

  vec_t        vecs [4];
  logic [63:0] d1, d2, e1, e2;
  string       long_s;
  int          cnt;

  initial begin
    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));

    long_s = "";
    for (int i = 0; i < 5; i++)
      long_s = {long_s, "The quick brown fox jumps over the lazy dog; light_hash absorbs bytes. "};
    vecs[0] = '{"empty",  "",                     IV_EXP};
    vecs[1] = '{"trojan", "H4rdw4r3_Tr0j4n",      64'h0};
    vecs[2] = '{"pi",     "3.141592653589793238", 64'h0};
    vecs[3] = '{"long",   long_s,                 64'h0};
    for (int v = 1; v < 4; v++) vecs[v].exp = model(IV_EXP, str2q(vecs[v].msg));

    // reset and idle
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_digest", digest, 64'h0);
    check("rst_ready", {63'h0, digest_ready}, 64'h0);
    check("rst_busy", {63'h0, dut.next_byte}, 64'h0);
    pulse(CMD_IDLE, 8'h5a);
    check("idle_digest", digest, 64'h0);
    check("idle_h", dut.r_h, IV_EXP);
    check("idle_busy", {63'h0, dut.next_byte}, 64'h0);

    // latency, dropped byte and ignored tail while busy
    pulse(CMD_HEAD, 8'h00);
    pulse(CMD_TAIL, 8'h00);
    check("empty_ready", {63'h0, digest_ready}, 64'h1);
    pulse(CMD_HEAD, 8'h00);
    pulse(CMD_MSG, 8'h48);
    check("msg_clears_ready", {63'h0, digest_ready}, 64'h0);
    cnt = 0;
    while (dut.next_byte === 1'b1 && cnt < 100) begin
      message_valid = (cnt == 5) || (cnt == 8);
      state         = (cnt == 8) ? CMD_TAIL : CMD_MSG;
      message_byte  = 8'h99;
      cnt++;
      tick();
    end
    message_valid = 1'b0;
    state         = CMD_IDLE;
    check("busy_cycles", 64'(cnt), 64'(ROUNDS));
    check("busy_tail_ignored", {63'h0, digest_ready}, 64'h0);
    pulse(CMD_TAIL, 8'h00);
    check("single_48", digest, model(IV_EXP, '{8'h48}));

    // golden strings, each hashed twice
    foreach (vecs[v]) begin
      hash_q(str2q(vecs[v].msg), d1);
      check(vecs[v].name, d1, vecs[v].exp);
      check({vecs[v].name, "_ready"}, {63'h0, digest_ready}, 64'h1);
      hash_q(str2q(vecs[v].msg), d2);
      check({vecs[v].name, "_rehash"}, d2, vecs[v].exp);
    end

    // avalanche
    e1 = model(IV_EXP, str2q("AlessandroAndGiacomo"));
    e2 = model(IV_EXP, str2q("AlessandroandGiacomo"));
    hash_q(str2q("AlessandroAndGiacomo"), d1);
    hash_q(str2q("AlessandroandGiacomo"), d2);
    check("aval_a", d1, e1);
    check("aval_b", d2, e2);
    check("aval_bits", {63'h0, ($countones(d1 ^ d2) >= 16)}, 64'h1);

    // continue after tail, and repeated tail
    pulse(CMD_HEAD, 8'h00);
    pulse(CMD_MSG, "a");
    wait_idle();
    pulse(CMD_TAIL, 8'h00);
    check("cont_a", digest, model(IV_EXP, str2q("a")));
    pulse(CMD_MSG, "b");
    check("cont_ready_clr", {63'h0, digest_ready}, 64'h0);
    wait_idle();
    pulse(CMD_TAIL, 8'h00);
    check("cont_ab", digest, model(IV_EXP, str2q("ab")));
    pulse(CMD_TAIL, 8'h00);
    check("retail_ab", digest, model(IV_EXP, str2q("ab")));

    // head abort during round 10
    pulse(CMD_HEAD, 8'h00);
    pulse(CMD_MSG, 8'h48);
    repeat (10) tick();
    pulse(CMD_HEAD, 8'h00);
    check("abort_busy", {63'h0, dut.next_byte}, 64'h0);
    check("abort_h", dut.r_h, IV_EXP);
    pulse(CMD_TAIL, 8'h00);
    check("abort_empty", digest, IV_EXP);

    // reset abort during round 10
    pulse(CMD_HEAD, 8'h00);
    pulse(CMD_MSG, 8'h48);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstab_busy", {63'h0, dut.next_byte}, 64'h0);
    check("rstab_h", dut.r_h, IV_EXP);
    check("rstab_digest", digest, 64'h0);
    check("rstab_ready", {63'h0, digest_ready}, 64'h0);
    pulse(CMD_HEAD, 8'h00);
    pulse(CMD_TAIL, 8'h00);
    check("rstab_empty", digest, IV_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_hash.md
Name: light_hash

Overview:
- Byte-serial 64-bit lightweight hash engine whose round function is built on the AES S-box.
- Host frames each message with a head command, streams bytes with message commands, and closes with a tail command; the 64-bit digest is then published.
- Sits as a leaf accelerator behind a simple valid/command interface; one byte is absorbed in ROUNDS clock cycles.

Parameters:
- ROUNDS, 32, compression rounds per message byte (one round per clock); legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- message_byte  input  8  message byte; sampled only with a valid message command.
- message_valid  input  1  command strobe; state/message_byte are sampled on a rising edge where it is 1.
- state  input  2  command: 2'b00 head, 2'b01 tail, 2'b10 message, 2'b11 no-op.
- digest  output  64  final hash value, registered.
- digest_ready  output  1  1 while digest holds a valid result.

Behaviour:
- Hash state: eight bytes H[0..7]. IV: H0..H7 = 0x34,0x55,0x0F,0x14,0xDA,0xC0,0x2B,0xEE.
- Internal register next_byte (exact name required; bench probes it hierarchically): 1 while a byte is being compressed (busy), 0 when a new byte may be sent.
- Reset (rst_n=0 at clock edge): H=IV, digest=64'h0, digest_ready=0, next_byte=0, round counter=0. Overrides any command or operation in progress.
- Commands are acted on only on edges with message_valid=1. With message_valid=0, or state=2'b11, nothing changes except an ongoing compression.
- Head: H=IV, digest_ready=0, digest unchanged, round counter=0, next_byte=0. Accepted even when busy; aborts the compression in progress.
- Message, accepted only when next_byte=0:
  - latch M=message_byte; set next_byte=1 on the same edge; digest_ready=0.
  - On each of the next ROUNDS edges, apply round r = 0..ROUNDS-1, with all i updated in parallel: H'[i] = rotl1(H[i]) XOR S(H[(i+1) mod 8] XOR M XOR r[7:0]). S is the AES forward S-box.
  - next_byte returns to 0 on the edge that applies the last round. Byte-to-byte latency is ROUNDS+1 cycles minimum.
  - Message commands received while next_byte=1 are ignored: byte dropped, no error.
- Tail, accepted only when next_byte=0:
  - on that edge, digest = {H[0],H[1],...,H[7]} (H[0] in bits 63:56) and digest_ready=1. Both are visible the following cycle.
  - H is left unchanged.
  - A tail received while busy is ignored.
- digest and digest_ready hold until the next accepted head, accepted message, or reset.
- A message after a tail without an intervening head continues absorbing from the current H.
- Repeated tail: re-publishes the same digest.
- Empty message (head then tail): digest = IV.

Decomposition:
- Package light_hash_pkg: command encodings (CMD_HEAD, CMD_TAIL, CMD_MSG, CMD_IDLE), the 64-bit IV constant, and the default ROUNDS.
- Sub-module aes_sbox: combinational 8-in/8-out AES forward S-box (256-entry case/LUT). light_hash instantiates it 8 times, one per state byte.
- Top level contains: H register file, round counter, next_byte busy flag, digest/digest_ready registers.

Test Plan:
- Reset/idle: hold rst_n=0 two cycles, then release. Require digest=0, digest_ready=0, next_byte=0. Pulse message_valid with state=2'b11 and confirm no change.
- Empty message: head pulse, then tail pulse. One cycle later require digest=64'h34550F14DAC02BEE and digest_ready=1.
- Latency/handshake: head, then message byte 0x48. Require next_byte=1 for exactly ROUNDS=32 cycles. A second byte pulsed while busy is ignored: digest equals single-byte 0x48 result from a software model of this spec.
- Golden strings: hash "H4rdw4r3_Tr0j4n", "3.141592653589793238", and a 300+ byte text. Each is framed by head/tail with bytes sent after next_byte falls. Every digest must equal the software model; re-hashing the same string must reproduce the identical digest.
- Avalanche: "AlessandroAndGiacomo" vs "AlessandroandGiacomo" must give different digests, each matching the model, with at least 16 bits differing.
- Abort/reset mid-operation: assert head, or separately rst_n=0, during round 10 of a byte. Require next_byte=0 next cycle and H=IV; a subsequent empty-message digest must equal IV.
